// File: rtl/gif_status_monitor.sv
// GIF playback status monitor: frame/loop/fps counters with debounced hold/clear keys,
// registered 7-segment stat outputs and status LEDs.

module gif_key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      level  <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_1 <= key_n;
      sync_2 <= sync_1;
      press  <= 1'b0;
      // Any cycle agreeing with the accepted level restarts the stability count
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_2;
        cnt   <= '0;
        press <= ~sync_2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

module gif_status_monitor #(
  parameter int unsigned CLK_HZ          = 50000000,
  parameter int unsigned FRAME_COUNT     = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_pulse,
  input  logic       key_hold_n,
  input  logic       key_clear_n,
  output logic [7:0] stat_frame,
  output logic [7:0] stat_fps,
  output logic [7:0] stat_loops,
  output logic [7:0] stat_leds
);

  localparam logic RUN  = 1'b0;
  localparam logic HOLD = 1'b1;

  localparam int unsigned TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(CLK_HZ - 1);
  localparam logic [7:0]    FRAME_LAST = 8'(FRAME_COUNT - 1);

  logic          hold_press;
  logic          clear_press;
  logic          state;
  logic [7:0]    frame_idx;
  logic [7:0]    loop_cnt;
  logic [7:0]    win_cnt;
  logic [7:0]    fps_q;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          heartbeat;

  gif_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_hold_key (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_hold_n),
    .press (hold_press)
  );

  gif_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_key (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_clear_n),
    .press (clear_press)
  );

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else if (hold_press) begin
      state <= (state == RUN) ? HOLD : RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_idx <= '0;
      loop_cnt  <= '0;
    end else if (clear_press) begin
      frame_idx <= '0;
      loop_cnt  <= '0;
    end else if (frame_pulse) begin
      if (frame_idx == FRAME_LAST) begin
        frame_idx <= '0;
        if (loop_cnt != 8'hFF) begin
          loop_cnt <= loop_cnt + 8'd1;
        end
      end else begin
        frame_idx <= frame_idx + 8'd1;
      end
    end
  end

  // A pulse landing on the tick belongs to the new window, not the latched one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt  <= '0;
      win_cnt   <= '0;
      fps_q     <= '0;
      heartbeat <= 1'b0;
    end else if (clear_press) begin
      tick_cnt <= '0;
      win_cnt  <= '0;
      fps_q    <= '0;
    end else if (tick) begin
      tick_cnt  <= '0;
      fps_q     <= win_cnt;
      win_cnt   <= frame_pulse ? 8'd1 : 8'd0;
      heartbeat <= ~heartbeat;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
      if (frame_pulse && (win_cnt != 8'hFF)) begin
        win_cnt <= win_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frame <= '0;
      stat_fps   <= '0;
      stat_loops <= '0;
      stat_leds  <= '0;
    end else begin
      if (state == RUN) begin
        stat_frame <= frame_idx;
        stat_fps   <= fps_q;
        stat_loops <= loop_cnt;
      end
      stat_leds <= {4'b0000, fps_q == 8'd0, heartbeat, loop_cnt == 8'hFF, state == HOLD};
    end
  end

endmodule

// File: tb/tb_gif_status_monitor.sv
// Directed bench for gif_status_monitor with CLK_HZ=100, FRAME_COUNT=4, DEBOUNCE_CYCLES=4.

module tb_gif_status_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       frame_pulse = 1'b0;
  logic       key_hold_n = 1'b1;
  logic       key_clear_n = 1'b1;
  logic [7:0] stat_frame;
  logic [7:0] stat_fps;
  logic [7:0] stat_loops;
  logic [7:0] stat_leds;

  int          vectors = 0;
  int          miscompares = 0;
  int unsigned ecount = 0;
  int unsigned tick_ref = 0;
  logic [7:0]  m_frame = 8'd0;
  logic [7:0]  m_loops = 8'd0;

  always #5 clk = ~clk;

  gif_status_monitor #(
    .CLK_HZ          (100),
    .FRAME_COUNT     (4),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_pulse (frame_pulse),
    .key_hold_n  (key_hold_n),
    .key_clear_n (key_clear_n),
    .stat_frame  (stat_frame),
    .stat_fps    (stat_fps),
    .stat_loops  (stat_loops),
    .stat_leds   (stat_leds)
  );

  task automatic step();
    @(posedge clk);
    ecount++;
    #1;
  endtask

  function automatic int unsigned rel();
    return (ecount - tick_ref) % 100;
  endfunction

  task automatic wait_rel(input int unsigned target);
    step();
    for (int n = 0; n < 200 && rel() != target; n++) step();
    if (rel() != target) begin
      miscompares++;
      $display("FAIL wait_rel: got %0d expected %0d", rel(), target);
    end
  endtask

  // One frame pulse; returns after the stat registers have caught up
  task automatic pulse();
    frame_pulse = 1'b1;
    step();
    frame_pulse = 1'b0;
    if (m_frame == 8'd3) begin
      m_frame = 8'd0;
      if (m_loops != 8'd255) m_loops++;
    end else begin
      m_frame++;
    end
    step();
  endtask

  task automatic press_hold();
    key_hold_n = 1'b0;
    repeat (8) step();
    key_hold_n = 1'b1;
    repeat (8) step();
  endtask

  task automatic press_clear();
    key_clear_n = 1'b0;
    repeat (7) step();
    tick_ref = ecount;
    m_frame  = 8'd0;
    m_loops  = 8'd0;
    step();
    key_clear_n = 1'b1;
    repeat (8) step();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (stat_frame !== 8'd0) begin miscompares++; $display("FAIL reset_frame: got %0d expected 0", stat_frame); end
    vectors++; if (stat_fps !== 8'd0) begin miscompares++; $display("FAIL reset_fps: got %0d expected 0", stat_fps); end
    vectors++; if (stat_loops !== 8'd0) begin miscompares++; $display("FAIL reset_loops: got %0d expected 0", stat_loops); end
    vectors++; if (stat_leds !== 8'h00) begin miscompares++; $display("FAIL reset_leds: got %h expected 00", stat_leds); end
    step();
    step();
    rst_n = 1'b1;
    tick_ref = ecount;
    step();
    step();
    vectors++; if (stat_leds !== 8'h08) begin miscompares++; $display("FAIL post_reset_leds: got %h expected 08", stat_leds); end
    vectors++; if (stat_frame !== 8'd0) begin miscompares++; $display("FAIL post_reset_frame: got %0d expected 0", stat_frame); end
  endtask

  task automatic test_frame_seq();
    logic [7:0] exp_f [5];
    logic [7:0] exp_l [5];
    exp_f = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1};
    exp_l = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1};
    for (int i = 0; i < 5; i++) begin
      pulse();
      vectors++; if (stat_frame !== exp_f[i]) begin miscompares++; $display("FAIL frame_seq[%0d]: got %0d expected %0d", i, stat_frame, exp_f[i]); end
      vectors++; if (stat_loops !== exp_l[i]) begin miscompares++; $display("FAIL loops_seq[%0d]: got %0d expected %0d", i, stat_loops, exp_l[i]); end
    end
  endtask

  task automatic test_fps();
    wait_rel(1);
    vectors++; if (stat_fps !== 8'd5) begin miscompares++; $display("FAIL fps_window1: got %0d expected 5", stat_fps); end
    repeat (7) pulse();
    wait_rel(99);
    pulse();
    vectors++; if (stat_fps !== 8'd7) begin miscompares++; $display("FAIL fps_window2: got %0d expected 7", stat_fps); end
    vectors++; if (stat_leds[3] !== 1'b0) begin miscompares++; $display("FAIL fps_zero_led: got %b expected 0", stat_leds[3]); end
    repeat (7) pulse();
    wait_rel(99);
    step();
    step();
    vectors++; if (stat_fps !== 8'd8) begin miscompares++; $display("FAIL fps_tick_pulse: got %0d expected 8", stat_fps); end
  endtask

  task automatic test_hold();
    logic [7:0] f0;
    logic [7:0] l0;
    key_hold_n = 1'b0; repeat (3) step();
    key_hold_n = 1'b1; step();
    key_hold_n = 1'b0; repeat (3) step();
    key_hold_n = 1'b1; repeat (6) step();
    vectors++; if (stat_leds[0] !== 1'b0) begin miscompares++; $display("FAIL bounce_no_toggle: got %b expected 0", stat_leds[0]); end
    pulse();
    vectors++; if (stat_frame !== m_frame) begin miscompares++; $display("FAIL run_live: got %0d expected %0d", stat_frame, m_frame); end
    press_hold();
    vectors++; if (stat_leds[0] !== 1'b1) begin miscompares++; $display("FAIL hold_led: got %b expected 1", stat_leds[0]); end
    f0 = m_frame;
    l0 = m_loops;
    vectors++; if (stat_frame !== f0) begin miscompares++; $display("FAIL hold_entry_frame: got %0d expected %0d", stat_frame, f0); end
    repeat (3) pulse();
    vectors++; if (stat_frame !== f0) begin miscompares++; $display("FAIL hold_frozen_frame: got %0d expected %0d", stat_frame, f0); end
    vectors++; if (stat_loops !== l0) begin miscompares++; $display("FAIL hold_frozen_loops: got %0d expected %0d", stat_loops, l0); end
    press_hold();
    vectors++; if (stat_leds[0] !== 1'b0) begin miscompares++; $display("FAIL resume_led: got %b expected 0", stat_leds[0]); end
    vectors++; if (stat_frame !== m_frame) begin miscompares++; $display("FAIL resume_frame: got %0d expected %0d", stat_frame, m_frame); end
    vectors++; if (stat_loops !== m_loops) begin miscompares++; $display("FAIL resume_loops: got %0d expected %0d", stat_loops, m_loops); end
  endtask

  task automatic test_clear_coincident();
    key_clear_n = 1'b0;
    repeat (6) step();
    frame_pulse = 1'b1;
    step();
    frame_pulse = 1'b0;
    tick_ref = ecount;
    m_frame  = 8'd0;
    m_loops  = 8'd0;
    step();
    vectors++; if (stat_frame !== 8'd0) begin miscompares++; $display("FAIL clear_vs_pulse_frame: got %0d expected 0", stat_frame); end
    vectors++; if (stat_fps !== 8'd0) begin miscompares++; $display("FAIL clear_vs_pulse_fps: got %0d expected 0", stat_fps); end
    key_clear_n = 1'b1;
    repeat (8) step();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 1100; i++) begin
      pulse();
      vectors++; if (stat_loops !== m_loops) begin miscompares++; $display("FAIL sat_loops[%0d]: got %0d expected %0d", i, stat_loops, m_loops); end
      vectors++; if (stat_leds[1] !== (m_loops == 8'd255)) begin miscompares++; $display("FAIL sat_led[%0d]: got %b expected %b", i, stat_leds[1], m_loops == 8'd255); end
    end
    vectors++; if (stat_loops !== 8'd255) begin miscompares++; $display("FAIL sat_final: got %0d expected 255", stat_loops); end
    press_clear();
    vectors++; if (stat_frame !== 8'd0) begin miscompares++; $display("FAIL clear_frame: got %0d expected 0", stat_frame); end
    vectors++; if (stat_fps !== 8'd0) begin miscompares++; $display("FAIL clear_fps: got %0d expected 0", stat_fps); end
    vectors++; if (stat_loops !== 8'd0) begin miscompares++; $display("FAIL clear_loops: got %0d expected 0", stat_loops); end
    vectors++; if (stat_leds[1] !== 1'b0) begin miscompares++; $display("FAIL clear_sat_led: got %b expected 0", stat_leds[1]); end
  endtask

  task automatic test_reset_mid();
    repeat (2) pulse();
    wait_rel(47);
    key_hold_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    vectors++; if (stat_frame !== 8'd0) begin miscompares++; $display("FAIL midrst_frame: got %0d expected 0", stat_frame); end
    vectors++; if (stat_fps !== 8'd0) begin miscompares++; $display("FAIL midrst_fps: got %0d expected 0", stat_fps); end
    vectors++; if (stat_loops !== 8'd0) begin miscompares++; $display("FAIL midrst_loops: got %0d expected 0", stat_loops); end
    vectors++; if (stat_leds !== 8'h00) begin miscompares++; $display("FAIL midrst_leds: got %h expected 00", stat_leds); end
    key_hold_n = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    tick_ref = ecount;
    m_frame = 8'd0;
    m_loops = 8'd0;
    for (int i = 1; i <= 101; i++) begin
      step();
      vectors++; if (stat_leds[0] !== 1'b0) begin miscompares++; $display("FAIL spurious_hold[%0d]: got %b expected 0", i, stat_leds[0]); end
      if (i == 100) begin
        vectors++; if (stat_leds[2] !== 1'b0) begin miscompares++; $display("FAIL early_tick: got %b expected 0", stat_leds[2]); end
      end
      if (i == 101) begin
        vectors++; if (stat_leds[2] !== 1'b1) begin miscompares++; $display("FAIL first_tick: got %b expected 1", stat_leds[2]); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame_seq();
    test_fps();
    test_hold();
    test_clear_coincident();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
